seq_signed_divider: RTL and testbench
=====================================

Name: seq_signed_divider

Overview:
Sequential two's-complement divider, the inverse operation of the team's combinational signed array multiplier. It accepts an N-bit signed dividend and divisor through a valid/ready handshake. It produces an N-bit signed quotient and remainder using restoring division on magnitudes, one bit per cycle, followed by sign correction. It sits beside the multiplier in the arithmetic datapath and shares its operand width convention.

Parameters:
N, 6, operand/result width in bits (two's complement), N >= 2

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  divider can accept operands
dividend  input  N  signed dividend
divisor  input  N  signed divisor
out_valid  output  1  results valid
out_ready  input  1  consumer accepts results
quotient  output  N  signed quotient, truncated toward zero
remainder  output  N  signed remainder, sign follows dividend

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, counter=0. Reset wins over any handshake in the same cycle. Reset mid-CALC/FIX/DONE aborts the operation; no result is emitted.
- States: IDLE, CALC, FIX, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid & in_ready the block performs the following, then goes to CALC.
  - Latches |dividend| and |divisor| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1), fits unsigned).
  - Latches sign_q = dividend[N-1]^divisor[N-1] and sign_r = dividend[N-1].
  - Clears the partial remainder (N+1 bits) and loads counter=N-1.
- CALC: each cycle performs one restoring step.
  - Shift {rem,quo} left 1 and bring in the next dividend MSB.
  - Trial = rem - |divisor| in N+1 bits.
  - If trial >= 0: rem=trial and quotient bit=1; else quotient bit=0.
  - When counter==0, go to FIX; otherwise decrement the counter. The state lasts exactly N cycles.
- FIX (1 cycle): quotient = sign_q ? -quo : quo, and remainder = sign_r ? -rem : rem, both truncated to N bits. Then go to DONE.
- DONE: holds quotient/remainder stable while out_ready=0. On out_ready=1, go to IDLE; the outputs keep their values, and out_valid drops the next cycle.
- Latency: out_valid rises N+2 clock edges after the acceptance edge. Throughput is one result per N+3 cycles minimum. There is no same-cycle accept in DONE.
- Overflow: -2^(N-1) / -1 gives quotient = -2^(N-1) (wraps) and remainder = 0. No flag is raised.
- Divide by zero, macro absent: the algorithm runs unchanged, so the raw quotient is all ones and the raw remainder is |dividend|. Result: quotient = -1 if dividend >= 0, else +1; remainder = dividend.
- Operand inputs are ignored outside the IDLE acceptance cycle.

Optional Feature:
DIV_ZERO_DETECT_EN
- Defined: adds output port div_zero (1 bit, reset 0).
  - An accepted divisor==0 skips CALC and FIX and goes directly IDLE->DONE, so out_valid rises 1 edge after acceptance.
  - It outputs quotient = all ones and remainder = dividend, with div_zero=1.
  - div_zero is held through DONE and cleared on the next acceptance.
- Undefined: no div_zero port. Divide by zero follows the macro-absent rule in Behaviour with full N+2 latency.

Decomposition:
- Shared package/include div_defs holds:
  - State encoding constants S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2, S_DONE=2'd3.
  - Default width constant DIV_N=6.
- One sub-module, div_step: combinational single restoring step (inputs rem, next bit, |divisor|; outputs new rem, quotient bit), parameterised by N. The top instantiates it once and iterates it in time.

Test Plan:
- N=6, 7 / 2 -> quotient=3, remainder=1, out_valid at edge 8 after accept.
- N=6, -7 / 2 -> quotient=-3 (6'b111101), remainder=-1 (6'b111111); 7 / -2 -> quotient=-3, remainder=1.
- N=6, -32 / -1 -> quotient=-32 (6'b100000), remainder=0; -32 / 1 -> quotient=-32, remainder=0.
- N=6, 5 / 0 -> macro off: quotient=-1, remainder=5 at N+2 latency; -5 / 0 -> quotient=1, remainder=-5. Macro on: div_zero=1, quotient=6'b111111, remainder=5, out_valid 1 edge after accept.
- Backpressure: 20 / 3 with out_ready held low 5 cycles -> quotient=6, remainder=2 stable; in_ready=0 throughout; one transfer when out_ready rises; a back-to-back second op then produces correct results.
- Reset: assert rst during CALC cycle 3 -> next cycle state IDLE, in_ready=1, out_valid=0, outputs 0; a following 9 / 4 returns quotient=2, remainder=1.

Source files
------------

// File: rtl/div_defs.sv
// -----------------------------------------------------------------------------
// div_defs
// Shared definitions for the sequential signed divider.
//   state_t : FSM encoding (S_IDLE=0, S_CALC=1, S_FIX=2, S_DONE=3)
//   DIV_N   : default operand/result width, matching the signed multiplier
// -----------------------------------------------------------------------------
package div_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DIV_N = 6;

endpackage : div_defs

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// The partial remainder is shifted left, the next dividend bit is brought in,
// and the divisor magnitude is subtracted; the subtraction is kept only when
// it does not go negative.
//
// Ports:
//   i_rem  [N:0]   partial remainder before the step
//   i_bit          next dividend bit (MSB first)
//   i_dvs  [N-1:0] divisor magnitude
//   o_rem  [N:0]   partial remainder after the step
//   o_qbit         quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_defs::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N:0]   i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_dvs,
    output logic [N:0]   o_rem,
    output logic         o_qbit
);

    // One guard bit above the shifted remainder holds the trial sign.
    logic [N+1:0] w_shifted;
    logic [N+1:0] w_trial;

    always_comb begin
        w_shifted = {i_rem, i_bit};
        w_trial   = w_shifted - {2'b00, i_dvs};
        o_qbit    = ~w_trial[N+1];
        o_rem     = o_qbit ? w_trial[N:0] : w_shifted[N:0];
    end

endmodule : div_step

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
// Sequential two's-complement divider: restoring division on magnitudes, one
// quotient bit per clock, followed by a one-cycle sign correction.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   dividend, divisor   N-bit signed operands
//   out_valid/out_ready result handshake (valid only in DONE)
//   quotient, remainder N-bit signed results, held until the next result
//   div_zero            (DIV_ZERO_DETECT_EN only) accepted divisor was zero
//
// Build option: define DIV_ZERO_DETECT_EN to add div_zero and a fast path that
// goes straight from IDLE to DONE on a zero divisor. Without it a zero divisor
// runs the normal algorithm (quotient -1/+1, remainder = dividend).
// -----------------------------------------------------------------------------
module seq_signed_divider
    import div_defs::*;
#(
    parameter int N = DIV_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] dividend,
    input  logic signed [N-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef DIV_ZERO_DETECT_EN
    output logic                div_zero,
`endif
    output logic signed [N-1:0] quotient,
    output logic signed [N-1:0] remainder
);

    localparam int CW = $clog2(N);

    // Magnitude of a two's-complement value; -2^(N-1) maps to 2^(N-1).
    function automatic logic [N-1:0] mag(input logic [N-1:0] x);
        return x[N-1] ? (~x + N'(1)) : x;
    endfunction

    function automatic logic [N-1:0] neg_if(input logic s, input logic [N-1:0] v);
        return s ? (~v + N'(1)) : v;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_quo;      // holds |dividend| at start; quotient bits shift in at LSB
    logic [N-1:0]  r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_sign_q;
    logic          r_sign_r;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          w_accept;
    logic          w_zero_div;
    logic [N:0]    w_rem;
    logic          w_qbit;

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign w_accept  = in_valid & in_ready;

`ifdef DIV_ZERO_DETECT_EN
    logic r_div_zero;
    assign div_zero   = r_div_zero;
    assign w_zero_div = (divisor == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    // {rem,quo} shifted left as one register: quo's MSB is the next dividend bit.
    div_step #(.N(N)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[N-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = w_zero_div ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == '0) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_div_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quo    <= mag(dividend);
                        r_dvs    <= mag(divisor);
                        r_rem    <= '0;
                        r_cnt    <= CW'(N - 1);
                        r_sign_q <= dividend[N-1] ^ divisor[N-1];
                        r_sign_r <= dividend[N-1];
`ifdef DIV_ZERO_DETECT_EN
                        r_div_zero <= w_zero_div;
                        if (w_zero_div) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
`endif
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem;
                    r_quo <= {r_quo[N-2:0], w_qbit};
                    if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_quotient  <= neg_if(r_sign_q, r_quo);
                    r_remainder <= neg_if(r_sign_r, r_rem[N-1:0]);
                end
                default: ;
            endcase
        end
    end

endmodule : seq_signed_divider

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic         div_zero;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_signed_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef DIV_ZERO_DETECT_EN
        .div_zero  (div_zero),
`endif
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one cycle and wait (bounded) for out_valid.
    // The acceptance edge counts as edge 1.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, output int edges);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        in_valid = 1'b0;
        dividend = 6'h2A;
        divisor  = 6'h15;
        edges    = 1;
        while (out_valid !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input int elat,
                          input logic edz);
        int edges;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        launch(a, b, edges);
        chk({tag, "_lat"}, 32'(edges), 32'(elat));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
`ifdef DIV_ZERO_DETECT_EN
        chk({tag, "_dz"}, 32'(div_zero), 32'(edz));
`else
        if (edz) chk({tag, "_dz_unexpected"}, 32'(edz), 32'd0);
`endif
        step();
        chk({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int edges;
        int lat_norm;
        int lat_zero;
        logic dz_on;
        lat_norm = N + 2;
`ifdef DIV_ZERO_DETECT_EN
        lat_zero = 1;
        dz_on    = 1'b1;
`else
        lat_zero = N + 2;
        dz_on    = 1'b0;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        rst = 1'b0;
        step();

        run_op("p7d2",   6'd7,     6'd2,     6'd3,     6'd1,     lat_norm, 1'b0);
        run_op("n7d2",   6'b111001, 6'd2,    6'b111101, 6'b111111, lat_norm, 1'b0);
        run_op("p7dn2",  6'd7,     6'b111110, 6'b111101, 6'd1,   lat_norm, 1'b0);
        run_op("m32dn1", 6'b100000, 6'b111111, 6'b100000, 6'd0,  lat_norm, 1'b0);
        run_op("m32d1",  6'b100000, 6'd1,    6'b100000, 6'd0,    lat_norm, 1'b0);
        run_op("p5d0",   6'd5,     6'd0,     6'b111111, 6'd5,    lat_zero, dz_on);
`ifdef DIV_ZERO_DETECT_EN
        run_op("n5d0",   6'b111011, 6'd0,    6'b111111, 6'b111011, lat_zero, 1'b1);
`else
        run_op("n5d0",   6'b111011, 6'd0,    6'd1,     6'b111011, lat_zero, 1'b0);
`endif
        run_op("p13d5",  6'd13,    6'd5,     6'd2,     6'd3,     lat_norm, 1'b0);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        launch(6'd20, 6'd3, edges);
        chk("bp_lat", 32'(edges), 32'(lat_norm));
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_q", 32'(quotient), 32'd6);
            chk("bp_r", 32'(remainder), 32'd2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_xfer_drop", 32'(out_valid), 32'd0);
        chk("bp_xfer_q_hold", 32'(quotient), 32'd6);
        run_op("b2b_n9d4", 6'b110111, 6'd4,  6'b111110, 6'b111111, lat_norm, 1'b0);

        // Reset during the third CALC cycle aborts the operation.
        in_valid = 1'b1;
        dividend = 6'd20;
        divisor  = 6'd3;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        chk("mid_rst_r", 32'(remainder), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("mid_rst_no_result", 32'(out_valid), 32'd0);
            step();
        end
        run_op("p9d4", 6'd9, 6'd4, 6'd2, 6'd1, lat_norm, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_signed_divider
